// File: rtl/ocm_noise_reader.sv
// Avalon-MM read master for the noise on-chip memory: fetches a window of words,
// unpacks each into SAMPLE_W lanes (lane 0 first) and streams them over valid/ready.
module ocm_noise_reader #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned NUM_WORDS = 8960
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  output logic [ADDR_W-1:0]     address2,
  output logic                  chipselect2,
  output logic                  write2,
  output logic [DATA_W/8-1:0]   byteenable2,
  output logic                  clken2,
  input  logic [DATA_W-1:0]     readdata2,
  output logic [SAMPLE_W-1:0]   sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  wrap_pulse,
  output logic                  done_pulse,
  output logic                  busy
);

  localparam int unsigned LANES  = DATA_W / SAMPLE_W;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(BASE_ADDR + NUM_WORDS - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, REQ, CAP, STREAM} state_t;

  state_t                             state;
  logic [ADDR_W-1:0]                  ptr;
  logic [LANE_W-1:0]                  lane;
  logic [LANES-1:0][SAMPLE_W-1:0]     word_reg;
  logic                               loop_r;
  logic                               stop_r;
  logic                               last_word;

  assign write2      = 1'b0;
  assign byteenable2 = '1;
  assign clken2      = 1'b1;

  // Playback FSM; pulses and the read strobe default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= BASE;
      lane         <= '0;
      word_reg     <= '0;
      loop_r       <= 1'b0;
      stop_r       <= 1'b0;
      last_word    <= 1'b0;
      address2     <= '0;
      chipselect2  <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      wrap_pulse   <= 1'b0;
      done_pulse   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      chipselect2 <= 1'b0;
      wrap_pulse  <= 1'b0;
      done_pulse  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            loop_r      <= loop;
            stop_r      <= 1'b0;
            ptr         <= BASE;
            address2    <= BASE;
            chipselect2 <= 1'b1;
            busy        <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (stop) stop_r <= 1'b1;
          // Pulse lands in the CAP cycle of the word that triggers the wrap.
          wrap_pulse <= loop_r && (ptr == LAST);
          state      <= CAP;
        end
        CAP: begin
          if (stop) stop_r <= 1'b1;
          word_reg     <= readdata2;
          lane         <= '0;
          sample_data  <= readdata2[SAMPLE_W-1:0];
          sample_valid <= 1'b1;
          last_word    <= (ptr == LAST);
          ptr          <= (ptr == LAST) ? BASE : ptr + ADDR_W'(1);
          state        <= STREAM;
        end
        STREAM: begin
          if (stop) stop_r <= 1'b1;
          if (sample_ready) begin
            if (lane != LANE_LAST) begin
              lane        <= lane + LANE_W'(1);
              sample_data <= word_reg[lane + LANE_W'(1)];
            end else begin
              sample_valid <= 1'b0;
              if (stop_r || stop) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else if (!loop_r && last_word) begin
                busy       <= 1'b0;
                done_pulse <= 1'b1;
                state      <= IDLE;
              end else begin
                address2    <= ptr;
                chipselect2 <= 1'b1;
                state       <= REQ;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ocm_noise_reader.sv
// Bench for ocm_noise_reader: cycle-level protocol model checked every cycle, plus
// literal expectations for sample order, latency, address sequence and pulse counts.
module tb_ocm_noise_reader;

  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned NUM_WORDS = 2;
  localparam int unsigned LANES     = DATA_W / SAMPLE_W;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic                  stop;
  logic                  loop;
  logic [ADDR_W-1:0]     address2;
  logic                  chipselect2;
  logic                  write2;
  logic [DATA_W/8-1:0]   byteenable2;
  logic                  clken2;
  logic [DATA_W-1:0]     readdata2;
  logic [SAMPLE_W-1:0]   sample_data;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  wrap_pulse;
  logic                  done_pulse;
  logic                  busy;

  ocm_noise_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W),
    .BASE_ADDR(BASE_ADDR), .NUM_WORDS(NUM_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .address2(address2), .chipselect2(chipselect2), .write2(write2),
    .byteenable2(byteenable2), .clken2(clken2), .readdata2(readdata2),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .wrap_pulse(wrap_pulse), .done_pulse(done_pulse), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory port: data valid the cycle after the read strobe.
  logic [DATA_W-1:0] mem [0:15];
  always @(posedge clk) if (chipselect2) readdata2 <= mem[address2[3:0]];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [SAMPLE_W-1:0] exp_sample(input int w, input int l);
    logic [DATA_W-1:0] wd;
    wd = mem[BASE_ADDR + w];
    return wd[l*SAMPLE_W +: SAMPLE_W];
  endfunction

  // Expected outputs for the current cycle plus playback position.
  bit e_cs, e_cap, e_valid, e_busy, e_wrap, e_done;
  int m_word, m_lane, m_cs_word;
  bit m_loop, m_stop;
  bit mon_en = 0;
  bit rand_ready = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_rise = -1;
  bit prev_dv = 0;
  int done_cnt = 0;
  int wrap_cnt = 0;
  logic [SAMPLE_W-1:0] got[$];
  int acc_cyc[$];
  logic [ADDR_W-1:0] cs_addr[$];

  task automatic model_cycle();
    bit acc, fin, start_ok, stop_eff, lastw, ends;
    bit n_cs, n_valid, n_busy, n_wrap, n_done;
    cyc++;
    if (mon_en) begin
      chk("chipselect2", 64'(chipselect2), 64'(e_cs));
      if (e_cs) chk("address2", 64'(address2), 64'(BASE_ADDR + m_cs_word));
      chk("sample_valid", 64'(sample_valid), 64'(e_valid));
      if (e_valid && sample_valid)
        chk("sample_data", 64'(sample_data), 64'(exp_sample(m_word, m_lane)));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("wrap_pulse", 64'(wrap_pulse), 64'(e_wrap));
      chk("done_pulse", 64'(done_pulse), 64'(e_done));
      chk("write2", 64'(write2), 64'(0));
    end
    if (!reset) begin
      if (sample_valid && sample_ready) begin
        got.push_back(sample_data);
        acc_cyc.push_back(cyc);
      end
      if (chipselect2) cs_addr.push_back(address2);
      if (done_pulse) done_cnt++;
      if (wrap_pulse) wrap_cnt++;
      if (sample_valid && !prev_dv && first_rise < 0) first_rise = cyc;
    end
    prev_dv = sample_valid;
    if (reset) begin
      {e_cs, e_cap, e_valid, e_busy, e_wrap, e_done} = '0;
      m_word = 0; m_lane = 0; m_cs_word = 0; m_loop = 0; m_stop = 0;
    end else begin
      start_ok = !e_busy && start && !stop;
      acc      = e_valid && sample_ready;
      fin      = acc && (m_lane == LANES - 1);
      stop_eff = m_stop || stop;
      lastw    = (m_word == NUM_WORDS - 1);
      ends     = fin && (stop_eff || (!m_loop && lastw));
      n_done   = fin && !stop_eff && !m_loop && lastw;
      n_wrap   = e_cs && m_loop && (m_cs_word == NUM_WORDS - 1);
      n_cs     = start_ok || (fin && !ends);
      n_valid  = e_cap || (e_valid && !fin);
      n_busy   = start_ok || (e_busy && !ends);
      if (e_cs) m_cs_word = (m_cs_word + 1) % NUM_WORDS;
      if (acc) begin
        if (m_lane == LANES - 1) begin
          m_lane = 0;
          m_word = (m_word + 1) % NUM_WORDS;
        end else m_lane++;
      end
      if (e_busy && stop) m_stop = 1;
      if (start_ok) begin
        m_word = 0; m_lane = 0; m_cs_word = 0; m_loop = loop; m_stop = 0;
        start_cyc = cyc; first_rise = -1;
      end
      e_cap = e_cs;
      e_cs = n_cs; e_valid = n_valid; e_busy = n_busy; e_wrap = n_wrap; e_done = n_done;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (rand_ready) sample_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start(input bit lp);
    loop = lp; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin step(); i++; end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic wait_samples(input int n, input int budget);
    int i;
    i = 0;
    while (got.size() < n && i < budget) begin step(); i++; end
    chk("sample_timeout", 64'(got.size() >= n), 64'(1));
  endtask

  initial begin
    int b, cb, db, wb, w1;
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; sample_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    step(); step();
    mon_en = 1;
    step();
    chk("rst_valid", 64'(sample_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_byteenable2", 64'(byteenable2), 64'hFF);
    chk("rst_clken2", 64'(clken2), 64'(1));
    chk("rst_address2", 64'(address2), 64'(0));
    reset = 1'b0;
    step();

    // One-shot playback of two words.
    b = got.size(); cb = cs_addr.size(); db = done_cnt;
    pulse_start(1'b0);
    wait_idle(100);
    repeat (4) step();
    chk("t1_count", 64'(got.size() - b), 64'(8));
    for (int i = 0; i < 8; i++) chk("t1_sample", 64'(got[b + i]), 64'(i + 1));
    chk("t1_latency", 64'(first_rise - start_cyc), 64'(3));
    chk("t1_steady", 64'(acc_cyc[b + 4] - acc_cyc[b]), 64'(6));
    chk("t1_cs_count", 64'(cs_addr.size() - cb), 64'(2));
    chk("t1_done", 64'(done_cnt - db), 64'(1));

    // Looping playback wraps back to sample 1.
    b = got.size(); cb = cs_addr.size(); wb = wrap_cnt;
    pulse_start(1'b1);
    wait_samples(b + 16, 200);
    stop = 1'b1; step(); stop = 1'b0;
    wait_idle(100);
    for (int i = 0; i < 16; i++) chk("t2_sample", 64'(got[b + i]), 64'((i % 8) + 1));
    for (int i = 0; i < 4; i++) chk("t2_addr", 64'(cs_addr[cb + i]), 64'(i % 2));
    w1 = 0;
    for (int i = cb; i < cs_addr.size(); i++) if (cs_addr[i] == 1) w1++;
    chk("t2_wrap_count", 64'(wrap_cnt - wb), 64'(w1));

    // Random backpressure with random window contents.
    mem[0] = {$urandom, $urandom};
    mem[1] = {$urandom, $urandom};
    b = got.size();
    rand_ready = 1;
    pulse_start(1'b1);
    repeat (300) step();
    stop = 1'b1; step(); stop = 1'b0;
    wait_idle(200);
    rand_ready = 0; sample_ready = 1'b1;
    chk("t3_progress", 64'(got.size() - b > 20), 64'(1));

    // Stop during lane 1 of word 0 finishes that word only.
    mem[0] = 64'h0004_0003_0002_0001;
    mem[1] = 64'h0008_0007_0006_0005;
    b = got.size(); cb = cs_addr.size();
    pulse_start(1'b1);
    wait_samples(b + 1, 20);
    stop = 1'b1; step(); stop = 1'b0;
    wait_idle(50);
    repeat (4) step();
    chk("t4_count", 64'(got.size() - b), 64'(4));
    for (int i = 0; i < 4; i++) chk("t4_sample", 64'(got[b + i]), 64'(i + 1));
    chk("t4_cs_count", 64'(cs_addr.size() - cb), 64'(1));

    // start with stop in IDLE does nothing; start while streaming is ignored.
    cb = cs_addr.size();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    repeat (3) step();
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_no_cs", 64'(cs_addr.size() - cb), 64'(0));
    b = got.size(); db = done_cnt;
    pulse_start(1'b0);
    wait_samples(b + 2, 20);
    start = 1'b1; step(); start = 1'b0;
    wait_idle(100);
    repeat (3) step();
    chk("t5_count", 64'(got.size() - b), 64'(8));
    chk("t5_cs_count", 64'(cs_addr.size() - cb), 64'(2));
    chk("t5_done", 64'(done_cnt - db), 64'(1));

    // Reset mid-stream, then replay from the start of the window.
    pulse_start(1'b1);
    wait_samples(got.size() + 6, 50);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_valid", 64'(sample_valid), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    step();
    b = got.size();
    pulse_start(1'b0);
    wait_idle(100);
    chk("t6_count", 64'(got.size() - b), 64'(8));
    for (int i = 0; i < 8; i++) chk("t6_sample", 64'(got[b + i]), 64'(i + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
